// File: rtl/fast_square_step_accum_pkg.sv
// Shared fast-square definitions: step FSM encoding and sample/record sizing.
package fast_square_step_accum_pkg;

  // Baseband sample width delivered by the receive stage.
  localparam int SAMPLE_WIDTH = 16;

  // Record window length used by the controller, log2 of clk64 ticks.
  localparam int RECORD_TICKS_LOG2 = 14;

  // Samples integrated per step track the record window so a full window
  // always yields exactly one result.
  localparam int DEFAULT_SAMPLES_LOG2 = RECORD_TICKS_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } step_state_e;

endpackage

// File: rtl/fast_square_iq_accum.sv
// Signed dual I/Q accumulator with clear, add and floor-mean shift-out.
// The mean outputs reflect the running sum including the sample currently
// presented, so the caller can register the result on the final-add edge.
module fast_square_iq_accum
  import fast_square_step_accum_pkg::*;
#(
  parameter int SAMPLES_LOG2 = DEFAULT_SAMPLES_LOG2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear_i,
  input  logic                           add_i,
  input  logic signed [SAMPLE_WIDTH-1:0] i_sample_i,
  input  logic signed [SAMPLE_WIDTH-1:0] q_sample_i,
  output logic signed [SAMPLE_WIDTH-1:0] mean_i_o,
  output logic signed [SAMPLE_WIDTH-1:0] mean_q_o
);

  // Wide enough for 2^SAMPLES_LOG2 full-scale samples, so no overflow.
  localparam int ACC_WIDTH = SAMPLE_WIDTH + SAMPLES_LOG2;

  logic signed [ACC_WIDTH-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_WIDTH-1:0] acc_i_d, acc_q_d;
  logic signed [ACC_WIDTH-1:0] sum_i_s, sum_q_s;

  // Sign-extend and add the presented sample; select clear/add/hold.
  always_comb begin
    sum_i_s = acc_i_q + {{SAMPLES_LOG2{i_sample_i[SAMPLE_WIDTH-1]}}, i_sample_i};
    sum_q_s = acc_q_q + {{SAMPLES_LOG2{q_sample_i[SAMPLE_WIDTH-1]}}, q_sample_i};
    if (clear_i) begin
      acc_i_d = {ACC_WIDTH{1'b0}};
      acc_q_d = {ACC_WIDTH{1'b0}};
    end else if (add_i) begin
      acc_i_d = sum_i_s;
      acc_q_d = sum_q_s;
    end else begin
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
    end
    // Taking the top bits is an arithmetic shift (floor); the mean of
    // int16 values always fits back into int16.
    mean_i_o = sum_i_s[SAMPLES_LOG2 +: SAMPLE_WIDTH];
    mean_q_o = sum_q_s[SAMPLES_LOG2 +: SAMPLE_WIDTH];
  end

  // Accumulator registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_i_q <= {ACC_WIDTH{1'b0}};
      acc_q_q <= {ACC_WIDTH{1'b0}};
    end else begin
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
    end
  end

endmodule

// File: rtl/fast_square_step_accum.sv
// Per-step I/Q integrator: averages 2^SAMPLES_LOG2 strobed samples inside
// each record window and emits one tagged mean pair per frequency step.
module fast_square_step_accum
  import fast_square_step_accum_pkg::*;
#(
  parameter int SAMPLES_LOG2 = DEFAULT_SAMPLES_LOG2,
  parameter int STEP_WIDTH   = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           step_reset,
  input  logic                           step_start,
  input  logic                           record,
  input  logic                           in_strobe,
  input  logic signed [SAMPLE_WIDTH-1:0] i_in,
  input  logic signed [SAMPLE_WIDTH-1:0] q_in,
  output logic                           out_strobe,
  output logic signed [SAMPLE_WIDTH-1:0] i_out,
  output logic signed [SAMPLE_WIDTH-1:0] q_out,
  output logic [STEP_WIDTH-1:0]          step_index,
  output logic                           short_step,
  output logic                           busy
);

  localparam logic [SAMPLES_LOG2-1:0] COUNT_ZERO = {SAMPLES_LOG2{1'b0}};
  localparam logic [SAMPLES_LOG2-1:0] COUNT_ONE  = {{(SAMPLES_LOG2-1){1'b0}}, 1'b1};
  localparam logic [SAMPLES_LOG2-1:0] COUNT_LAST = {SAMPLES_LOG2{1'b1}};
  localparam logic [STEP_WIDTH-1:0]   INDEX_ZERO = {STEP_WIDTH{1'b0}};
  localparam logic [STEP_WIDTH-1:0]   INDEX_ONE  = {{(STEP_WIDTH-1){1'b0}}, 1'b1};

  step_state_e                    state_q, state_d;
  logic [SAMPLES_LOG2-1:0]        count_q, count_d;
  logic                           clear_s, add_s, emit_s, abort_s;
  logic signed [SAMPLE_WIDTH-1:0] mean_i_s, mean_q_s;
  logic                           out_strobe_q, short_step_q, busy_q, first_q;
  logic signed [SAMPLE_WIDTH-1:0] i_out_q, q_out_q;
  logic [STEP_WIDTH-1:0]          step_index_q;

  fast_square_iq_accum #(
    .SAMPLES_LOG2 (SAMPLES_LOG2)
  ) u_iq_accum (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (clear_s),
    .add_i      (add_s),
    .i_sample_i (i_in),
    .q_sample_i (q_in),
    .mean_i_o   (mean_i_s),
    .mean_q_o   (mean_q_s)
  );

  // Next-state decode; enable low freezes IDLE/ACCUM, EMIT always lasts one cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    clear_s = 1'b0;
    add_s   = 1'b0;
    emit_s  = 1'b0;
    abort_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && step_start) begin
          clear_s = 1'b1;
          count_d = COUNT_ZERO;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          state_d = ST_ACCUM;
        end else if (step_start) begin
          // Restart beats any coincident sample.
          clear_s = 1'b1;
          abort_s = 1'b1;
          count_d = COUNT_ZERO;
        end else if (!record) begin
          if (count_q != COUNT_ZERO) begin
            abort_s = 1'b1;
            count_d = COUNT_ZERO;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else if (in_strobe) begin
          add_s = 1'b1;
          if (count_q == COUNT_LAST) begin
            emit_s  = 1'b1;
            count_d = COUNT_ZERO;
            state_d = ST_EMIT;
          end else begin
            count_d = count_q + COUNT_ONE;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_EMIT: begin
        if (enable && step_start) begin
          clear_s = 1'b1;
          count_d = COUNT_ZERO;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        count_d = COUNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; results latch on the Nth-sample edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      count_q      <= COUNT_ZERO;
      out_strobe_q <= 1'b0;
      i_out_q      <= {SAMPLE_WIDTH{1'b0}};
      q_out_q      <= {SAMPLE_WIDTH{1'b0}};
      step_index_q <= INDEX_ZERO;
      short_step_q <= 1'b0;
      busy_q       <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      out_strobe_q <= emit_s;
      busy_q       <= (state_d != ST_IDLE);
      if (abort_s) begin
        short_step_q <= 1'b1;
      end else begin
        short_step_q <= short_step_q;
      end
      if (emit_s) begin
        i_out_q <= mean_i_s;
        q_out_q <= mean_q_s;
        if (step_reset || first_q) begin
          step_index_q <= INDEX_ZERO;
          first_q      <= 1'b0;
        end else begin
          step_index_q <= step_index_q + INDEX_ONE;
        end
      end else if (step_reset) begin
        step_index_q <= INDEX_ZERO;
        first_q      <= 1'b1;
      end else begin
        step_index_q <= step_index_q;
      end
    end
  end

  assign out_strobe = out_strobe_q;
  assign i_out      = i_out_q;
  assign q_out      = q_out_q;
  assign step_index = step_index_q;
  assign short_step = short_step_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fast_square_step_accum.sv
// Randomized self-checking bench for fast_square_step_accum (N = 4, 2-bit index).
module tb_fast_square_step_accum;

  localparam int SL = 2;
  localparam int SW = 2;
  localparam int N  = 1 << SL;

  logic clock = 1'b0;
  logic reset, enable, step_reset, step_start, record, in_strobe;
  logic signed [15:0] i_in, q_in;
  logic out_strobe, short_step, busy;
  logic signed [15:0] i_out, q_out;
  logic [SW-1:0] step_index;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should hold right now.
  int exp_i = 0, exp_q = 0, exp_idx = 0;
  bit exp_first = 1'b1;
  bit exp_short = 1'b0;
  int smp_i [N];
  int smp_q [N];

  always #5 clock = ~clock;

  fast_square_step_accum #(.SAMPLES_LOG2(SL), .STEP_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .step_reset(step_reset),
    .step_start(step_start), .record(record), .in_strobe(in_strobe),
    .i_in(i_in), .q_in(q_in), .out_strobe(out_strobe), .i_out(i_out),
    .q_out(q_out), .step_index(step_index), .short_step(short_step), .busy(busy)
  );

  task automatic check_value(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Mean rounded toward minus infinity.
  function automatic int floor_mean(input int s);
    int m;
    m = s / N;
    if ((s % N) != 0 && s < 0) m = m - 1;
    return m;
  endfunction

  task automatic check_all(input string tag, input bit strobe, input bit bsy);
    check_value({tag, ".out_strobe"}, {31'd0, out_strobe}, {31'd0, strobe});
    check_value({tag, ".i_out"}, i_out, exp_i);
    check_value({tag, ".q_out"}, q_out, exp_q);
    check_value({tag, ".step_index"}, {30'd0, step_index}, exp_idx);
    check_value({tag, ".short_step"}, {31'd0, short_step}, {31'd0, exp_short});
    check_value({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
  endtask

  // A full window using smp_i/smp_q with random enable/strobe gaps.
  task automatic run_step(input string tag);
    int si, sq, gaps;
    si = 0;
    sq = 0;
    enable = 1'b1; record = 1'b1;
    step_start = 1'b1; in_strobe = 1'b1; i_in = 16'sd1000; q_in = -16'sd1000;
    tick();
    step_start = 1'b0; in_strobe = 1'b0;
    check_value({tag, ".busy_start"}, {31'd0, busy}, 32'sd1);
    if ($urandom_range(0, 1) == 1) begin
      record = 1'b0;
      repeat (2) tick();
      check_value({tag, ".wait_busy"}, {31'd0, busy}, 32'sd1);
      record = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        if ($urandom_range(0, 1) == 1) begin
          enable = 1'b0; in_strobe = 1'b1; i_in = 16'($urandom); q_in = 16'($urandom);
        end else begin
          enable = 1'b1; in_strobe = 1'b0;
        end
        tick();
        check_value({tag, ".gap_strobe"}, {31'd0, out_strobe}, 32'sd0);
      end
      enable = 1'b1; in_strobe = 1'b1;
      i_in = 16'(smp_i[k]); q_in = 16'(smp_q[k]);
      si += smp_i[k];
      sq += smp_q[k];
      tick();
    end
    in_strobe = 1'b0;
    exp_i = floor_mean(si);
    exp_q = floor_mean(sq);
    exp_idx = exp_first ? 0 : (exp_idx + 1) % (1 << SW);
    exp_first = 1'b0;
    check_all({tag, ".emit"}, 1'b1, 1'b1);
    tick();
    check_all({tag, ".after"}, 1'b0, 1'b0);
  endtask

  // Starts a window and feeds n samples of value 5 without completing it.
  task automatic partial(input int n);
    enable = 1'b1; record = 1'b1; in_strobe = 1'b0;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_strobe = 1'b1; i_in = 16'sd5; q_in = 16'sd5;
      tick();
    end
    in_strobe = 1'b0;
  endtask

  task automatic fill(input int vi, input int vq);
    for (int k = 0; k < N; k++) begin
      smp_i[k] = vi;
      smp_q[k] = vq;
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; step_reset = 1'b0; step_start = 1'b0;
    record = 1'b0; in_strobe = 1'b0; i_in = 16'sd0; q_in = 16'sd0;
    repeat (2) tick();
    reset = 1'b1;
    check_all("reset", 1'b0, 1'b0);

    fill(100, -100);
    run_step("basic");

    fill(0, 0); smp_i[0] = 1; smp_q[0] = -1;
    run_step("floor");

    fill(-32768, 32767);
    run_step("extreme");

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        smp_i[k] = $signed(16'($urandom));
        smp_q[k] = $signed(16'($urandom));
      end
      run_step("random");
    end
    check_value("short_clear", {31'd0, short_step}, 32'sd0);

    // Record drops mid-window: abort without emission.
    partial(2);
    record = 1'b0;
    tick();
    record = 1'b1;
    exp_short = 1'b1;
    check_all("abort", 1'b0, 1'b0);

    // Restart after 3 samples; coincident sample on restart is dropped.
    partial(3);
    fill(7, -7);
    run_step("restart");

    // Reset mid-window clears everything.
    partial(3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_i = 0; exp_q = 0; exp_idx = 0; exp_first = 1'b1; exp_short = 1'b0;
    check_all("midreset", 1'b0, 1'b0);
    record = 1'b1; enable = 1'b1; in_strobe = 1'b1; i_in = 16'sd9; q_in = 16'sd9;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_value("idle_strobe", {31'd0, out_strobe}, 32'sd0);
    end
    in_strobe = 1'b0;

    // Index wraps modulo 4, then step_reset forces the next report to 0.
    for (int s = 0; s < 5; s++) begin
      fill(s * 3, -s);
      run_step("wrap");
    end
    step_reset = 1'b1;
    tick();
    step_reset = 1'b0;
    exp_idx = 0; exp_first = 1'b1;
    check_value("step_reset_idx", {30'd0, step_index}, exp_idx);
    fill(-2, 2);
    run_step("after_sreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
